// File: rtl/tdm_demux_1_8_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared types and constants for the 1-to-8 TDM demultiplexer.
//   state_t : sync-tracking FSM states (HUNT, LOCKED)
//   NCH     : number of channels per frame
//   SLOT_W  : width of the slot index
//   MISS_W  : width of the missing-sync counter (MISS_MAX is limited to 1..7)
// ---------------------------------------------------------------------------
package tdm_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int NCH    = 8;
   localparam int SLOT_W = 3;
   localparam int MISS_W = 3;

endpackage : tdm_pkg

// File: rtl/tdm_demux_1_8_if.sv
// ---------------------------------------------------------------------------
// tdm_demux_1_8_if
// Serial-link side and channel-output side of the TDM demultiplexer.
//   din, valid, sync : serial beat from the link (driven by the master)
//   Y                : 8 channel outputs, channel k at Y[k*W +: W]
//   S                : slot index the next valid beat is written to
//   frame_valid      : one-cycle pulse, Y holds a new complete frame
//   locked           : frame alignment acquired
//   sync_err         : one-cycle pulse, sync seen away from slot 0 while locked
// Modports: master = link driver / output consumer, slave = demultiplexer.
// ---------------------------------------------------------------------------
interface tdm_demux_1_8_if #(
   parameter int W = 1
);

   logic [W-1:0]   din;
   logic           valid;
   logic           sync;
   logic [8*W-1:0] Y;
   logic [2:0]     S;
   logic           frame_valid;
   logic           locked;
   logic           sync_err;

   modport master (
      output din, valid, sync,
      input  Y, S, frame_valid, locked, sync_err
   );

   modport slave (
      input  din, valid, sync,
      output Y, S, frame_valid, locked, sync_err
   );

endinterface : tdm_demux_1_8_if

// File: rtl/tdm_demux_1_8_slot_cnt.sv
// ---------------------------------------------------------------------------
// tdm_slot_cnt
// Slot counter for the TDM demultiplexer.
//   clk, rst : clock, asynchronous active-high reset
//   advance  : step to the next slot (wraps 7 -> 0)
//   load_one : jump to slot 1 (the current beat was taken as slot 0)
//   clear    : force slot 0
//   slot     : current slot index
//   wrap     : current slot is the last slot of the frame
// Priority: clear > load_one > advance.
// ---------------------------------------------------------------------------
module tdm_slot_cnt
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   input  logic              load_one,
   input  logic              clear,
   output logic [SLOT_W-1:0] slot,
   output logic              wrap
);

   logic [SLOT_W-1:0] slot_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_reg <= '0;
      end else if (clear) begin
         slot_reg <= '0;
      end else if (load_one) begin
         slot_reg <= SLOT_W'(1);
      end else if (advance) begin
         slot_reg <= slot_reg + SLOT_W'(1);
      end
   end

   assign slot = slot_reg;
   assign wrap = (slot_reg == SLOT_W'(NCH - 1));

endmodule : tdm_slot_cnt

// File: rtl/tdm_demux_1_8.sv
// ---------------------------------------------------------------------------
// tdm_demux_1_8
// Receive end of an 8:1 TDM serial link. Valid beats are written into a
// shadow register at the current slot; the slot-7 beat publishes the shadow
// plus that beat to Y in one edge. A HUNT/LOCKED FSM tracks frame alignment
// using the sync flag on slot 0.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : tdm_demux_1_8_if.slave (din/valid/sync in, Y/S/flags out)
// Parameters:
//   W        : sample width per channel
//   MISS_MAX : consecutive slot-0 beats without sync before lock is dropped
// ---------------------------------------------------------------------------
module tdm_demux_1_8
   import tdm_pkg::*;
#(
   parameter int W        = 1,
   parameter int MISS_MAX = 2
) (
   input  logic                clk,
   input  logic                rst,
   tdm_demux_1_8_if.slave      bus
);

   state_t              state_reg, state_next;
   logic [MISS_W-1:0]   miss_reg, miss_next;
   logic [W-1:0]        shadow_reg [NCH-1];
   logic [NCH*W-1:0]    y_reg;
   logic                frame_valid_reg, frame_valid_next;
   logic                sync_err_reg, sync_err_next;

   logic [SLOT_W-1:0]   slot;
   logic                slot_wrap;
   logic                cnt_advance, cnt_load_one, cnt_clear;
   logic                shadow_we;
   logic [SLOT_W-1:0]   shadow_idx;
   logic                publish;
   logic [NCH*W-1:0]    frame_word;

   tdm_slot_cnt u_slot_cnt (
      .clk      (clk),
      .rst      (rst),
      .advance  (cnt_advance),
      .load_one (cnt_load_one),
      .clear    (cnt_clear),
      .slot     (slot),
      .wrap     (slot_wrap)
   );

   // Completed frame: slots 0..6 from the shadow, slot 7 straight from din
   // so the publish happens on the edge that samples the last beat.
   genvar gi;
   generate
      for (gi = 0; gi < NCH - 1; gi++) begin : g_pack
         assign frame_word[gi*W +: W] = shadow_reg[gi];
      end
   endgenerate
   assign frame_word[(NCH-1)*W +: W] = bus.din;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= HUNT;
         miss_reg        <= '0;
         y_reg           <= '0;
         frame_valid_reg <= 1'b0;
         sync_err_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         miss_reg        <= miss_next;
         frame_valid_reg <= frame_valid_next;
         sync_err_reg    <= sync_err_next;
         if (publish) begin
            y_reg <= frame_word;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH - 1; i++) begin
            shadow_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH - 1; i++) begin
            if (shadow_we && (shadow_idx == SLOT_W'(i))) begin
               shadow_reg[i] <= bus.din;
            end
         end
      end
   end

   always_comb begin
      state_next       = state_reg;
      miss_next        = miss_reg;
      frame_valid_next = 1'b0;
      sync_err_next    = 1'b0;
      cnt_advance      = 1'b0;
      cnt_load_one     = 1'b0;
      cnt_clear        = 1'b0;
      shadow_we        = 1'b0;
      shadow_idx       = slot;
      publish          = 1'b0;

      unique case (state_reg)
         HUNT: begin
            if (bus.valid) begin
               if (bus.sync) begin
                  shadow_we    = 1'b1;
                  shadow_idx   = '0;
                  cnt_load_one = 1'b1;
                  miss_next    = '0;
                  state_next   = LOCKED;
               end else begin
                  cnt_clear = 1'b1;
               end
            end
         end

         LOCKED: begin
            if (bus.valid) begin
               if (slot == '0) begin
                  if (bus.sync) begin
                     miss_next   = '0;
                     shadow_we   = 1'b1;
                     cnt_advance = 1'b1;
                  end else if (miss_reg == MISS_W'(MISS_MAX - 1)) begin
                     // Too many frames without sync: the beat is dropped.
                     miss_next  = '0;
                     cnt_clear  = 1'b1;
                     state_next = HUNT;
                  end else begin
                     miss_next   = miss_reg + MISS_W'(1);
                     shadow_we   = 1'b1;
                     cnt_advance = 1'b1;
                  end
               end else if (bus.sync) begin
                  // Realign: drop the partial frame, this beat becomes slot 0.
                  sync_err_next = 1'b1;
                  shadow_we     = 1'b1;
                  shadow_idx    = '0;
                  cnt_load_one  = 1'b1;
                  miss_next     = '0;
               end else if (slot_wrap) begin
                  publish          = 1'b1;
                  frame_valid_next = 1'b1;
                  cnt_advance      = 1'b1;
               end else begin
                  shadow_we   = 1'b1;
                  cnt_advance = 1'b1;
               end
            end
         end

         default: begin
            state_next = HUNT;
         end
      endcase
   end

   assign bus.Y           = y_reg;
   assign bus.S           = slot;
   assign bus.frame_valid = frame_valid_reg;
   assign bus.locked      = (state_reg == LOCKED);
   assign bus.sync_err    = sync_err_reg;

endmodule : tdm_demux_1_8

// File: tb/tb_tdm_demux_1_8.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1_8
// Directed bench for tdm_demux_1_8 (W=1, MISS_MAX=2). Expected frames are
// queued when their slot-7 beat is driven and compared when frame_valid
// fires. Inputs change just after the falling edge; outputs are read there.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1_8;

   localparam int W        = 1;
   localparam int MISS_MAX = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   tdm_demux_1_8_if #(.W(W)) bus ();

   tdm_demux_1_8 #(.W(W), .MISS_MAX(MISS_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total       = 0;
   int bad         = 0;
   int cyc         = 0;
   int fv_count    = 0;
   int last_fv_cyc = -1;
   logic [7:0] exp_q [$];

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every frame_valid pulse must match the oldest queued frame.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.frame_valid) begin
            fv_count++;
            last_fv_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_frame_valid", 32'd1, 32'd0);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               check("frame_y", 32'(bus.Y), 32'(e));
               $display("frame: Y=%02h expected=%02h cycle=%0d", bus.Y, e, cyc);
            end
         end
         if (bus.frame_valid || bus.sync_err) begin
            check("fv_serr_exclusive", 32'(bus.frame_valid & bus.sync_err), 32'd0);
         end
      end
   end

   task automatic step(input logic v, input logic s, input logic d);
      bus.valid = v;
      bus.sync  = s;
      bus.din   = d;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] w, input bit with_sync,
                             input bit expect_pub, input int gap);
      for (int k = 0; k < 8; k++) begin
         if (k == 4 && gap > 0) idle(gap);
         if (k == 7 && expect_pub) exp_q.push_back(w);
         step(1'b1, logic'(with_sync && k == 0), w[k]);
      end
   endtask

   initial begin
      int t0;
      int fvc;
      int fv_at [4];
      logic [7:0] full_words [4];

      full_words[0] = 8'h01;
      full_words[1] = 8'h80;
      full_words[2] = 8'h3C;
      full_words[3] = 8'hC3;

      bus.valid = 1'b0;
      bus.sync  = 1'b0;
      bus.din   = '0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset_Y", 32'(bus.Y), 32'd0);
      check("reset_S", 32'(bus.S), 32'd0);
      check("reset_locked", 32'(bus.locked), 32'd0);
      check("reset_fv", 32'(bus.frame_valid), 32'd0);
      check("reset_serr", 32'(bus.sync_err), 32'd0);
      rst = 1'b0;

      // HUNT drops beats without sync
      step(1'b1, 1'b0, 1'b1);
      check("hunt_S", 32'(bus.S), 32'd0);
      check("hunt_locked", 32'(bus.locked), 32'd0);

      // Lock and single frame
      t0 = cyc;
      send_frame(8'h4D, 1'b1, 1'b1, 0);
      check("lock_locked", 32'(bus.locked), 32'd1);
      check("lock_fv", 32'(bus.frame_valid), 32'd1);
      check("lock_S", 32'(bus.S), 32'd0);
      check("lock_latency", 32'(last_fv_cyc - t0), 32'd8);
      idle(1);
      check("fv_one_cycle", 32'(bus.frame_valid), 32'd0);
      check("y_hold", 32'(bus.Y), 32'h4D);

      // Gapped frame: same data, publish delayed by the gap
      t0 = cyc;
      send_frame(8'h4D, 1'b1, 1'b1, 3);
      check("gap_fv", 32'(bus.frame_valid), 32'd1);
      check("gap_latency", 32'(last_fv_cyc - t0), 32'd11);

      // Misaligned sync at S=5
      step(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0);
      check("mis_S_before", 32'(bus.S), 32'd5);
      step(1'b1, 1'b1, 1'b1);
      check("mis_serr", 32'(bus.sync_err), 32'd1);
      check("mis_no_fv", 32'(bus.frame_valid), 32'd0);
      check("mis_S_after", 32'(bus.S), 32'd1);
      check("mis_Y_hold", 32'(bus.Y), 32'h4D);
      check("mis_locked", 32'(bus.locked), 32'd1);
      step(1'b1, 1'b0, 1'b1);
      check("mis_serr_pulse", 32'(bus.sync_err), 32'd0);
      for (int k = 2; k < 8; k++) begin
         if (k == 7) exp_q.push_back(8'hFF);
         step(1'b1, 1'b0, 1'b1);
      end
      check("mis_new_fv", 32'(bus.frame_valid), 32'd1);

      // Lock loss: two frames without sync at slot 0
      send_frame(8'h5A, 1'b0, 1'b1, 0);
      check("loss_first_fv", 32'(bus.frame_valid), 32'd1);
      check("loss_still_locked", 32'(bus.locked), 32'd1);
      fvc = fv_count;
      step(1'b1, 1'b0, 1'b1);
      check("loss_locked", 32'(bus.locked), 32'd0);
      check("loss_S", 32'(bus.S), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 1'b1);
         check("loss_ignored_S", 32'(bus.S), 32'd0);
         check("loss_ignored_locked", 32'(bus.locked), 32'd0);
      end
      check("loss_no_fv", 32'(fv_count - fvc), 32'd0);

      // Full-rate stream of 4 synced frames
      fvc = fv_count;
      for (int f = 0; f < 4; f++) begin
         send_frame(full_words[f], 1'b1, 1'b1, 0);
         fv_at[f] = last_fv_cyc;
      end
      check("full_count", 32'(fv_count - fvc), 32'd4);
      for (int f = 1; f < 4; f++) begin
         check("full_interval", 32'(fv_at[f] - fv_at[f-1]), 32'd8);
      end

      // Reset mid-stream with A5 published
      send_frame(8'hA5, 1'b1, 1'b1, 0);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1);
      check("pre_rst_Y", 32'(bus.Y), 32'hA5);
      check("pre_rst_S", 32'(bus.S), 32'd3);
      rst = 1'b1;
      #1;
      check("rst_Y", 32'(bus.Y), 32'd0);
      check("rst_S", 32'(bus.S), 32'd0);
      check("rst_locked", 32'(bus.locked), 32'd0);
      check("rst_fv", 32'(bus.frame_valid), 32'd0);
      bus.valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_hold_fv", 32'(bus.frame_valid), 32'd0);
      rst = 1'b0;
      idle(2);

      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_tdm_demux_1_8
